// File: rtl/dec_counter_16.sv
// dec_counter_16: loadable 16-bit down-counter with zero detect and a
// registered terminal-count pulse. Used as the loop/delay counter beside
// the PC. Decrement is a 16-stage half-subtractor borrow ripple.

// Single-bit half-subtractor: a - b, producing difference and borrow-out.
module dec_counter_16_hsub (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  // Difference is XOR; a borrow is needed when subtracting 1 from 0.
  always_comb begin
    diff   = a ^ b;
    borrow = ~a & b;
  end

endmodule

module dec_counter_16 (
  input  logic        clk,
  input  logic        re_n,
  input  logic [15:0] load,
  input  logic        ld,
  input  logic        dec,
  input  logic        wrap,
  output logic [15:0] O,
  output logic        zero,
  output logic        tc
);

  logic [15:0] count_q;
  logic [15:0] count_d;
  logic        tc_q;
  logic        tc_d;

  // Borrow chain: borrow[0] is the constant subtrahend of 1. The borrow
  // out of bit 15 only signals underflow, which wrap/saturate logic
  // handles explicitly from the zero flag, so it is not generated.
  logic [15:0] borrow;
  logic [15:0] dec_value;
  logic        count_is_zero;
  logic        count_is_one;

  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_borrow_chain
      if (gi < 15) begin : g_mid
        dec_counter_16_hsub u_hsub (
          .a      (count_q[gi]),
          .b      (borrow[gi]),
          .diff   (dec_value[gi]),
          .borrow (borrow[gi+1])
        );
      end else begin : g_msb
        // Final stage: difference only, borrow-out discarded.
        assign dec_value[gi] = count_q[gi] ^ borrow[gi];
      end
    end
  endgenerate

  // Zero/one detection on the current count (zero is the 16-input NOR).
  always_comb begin
    count_is_zero = ~|count_q;
    count_is_one  = (count_q[15:1] == 15'd0) & count_q[0];
  end

  // Next-state selection: load beats decrement; at zero either wrap or saturate.
  always_comb begin
    count_d = count_q;
    if (ld) begin
      count_d = load;
    end else if (dec) begin
      if (!count_is_zero) begin
        count_d = dec_value;
      end else if (wrap) begin
        count_d = 16'hFFFF;
      end else begin
        count_d = 16'h0000;
      end
    end
  end

  // Terminal count fires only for a genuine 1 -> 0 decrement.
  always_comb begin
    tc_d = ~ld & dec & count_is_one;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      count_q <= 16'h0000;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  // Outputs: count and tc straight from flops, zero combinational from the count.
  always_comb begin
    O    = count_q;
    tc   = tc_q;
    zero = count_is_zero;
  end

endmodule

// File: tb/tb_dec_counter_16.sv
// Self-checking bench for dec_counter_16: directed scenarios with literal
// expectations plus randomized traffic checked against an arithmetic model.
`timescale 1ns/1ps

module tb_dec_counter_16;

  logic        clk = 1'b0;
  logic        re_n;
  logic [15:0] load;
  logic        ld;
  logic        dec;
  logic        wrap;
  logic [15:0] O;
  logic        zero;
  logic        tc;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain integer count and tc flag.
  int m_cnt;
  bit m_tc;

  always #5 clk = ~clk;

  dec_counter_16 dut (
    .clk  (clk),
    .re_n (re_n),
    .load (load),
    .ld   (ld),
    .dec  (dec),
    .wrap (wrap),
    .O    (O),
    .zero (zero),
    .tc   (tc)
  );

  // Compare all three outputs with the given expectation.
  task automatic check(input string name, input int exp_cnt, input bit exp_tc);
    logic [15:0] e;
    e = exp_cnt[15:0];
    n_checks++;
    if (O !== e) begin
      n_fail++;
      $display("FAIL %s O: got %h expected %h", name, O, e);
    end
    n_checks++;
    if (zero !== (e == 16'h0000)) begin
      n_fail++;
      $display("FAIL %s zero: got %b expected %b", name, zero, (e == 16'h0000));
    end
    n_checks++;
    if (tc !== exp_tc) begin
      n_fail++;
      $display("FAIL %s tc: got %b expected %b", name, tc, exp_tc);
    end
  endtask

  // Model of one rising edge, written from the counter's rules.
  task automatic model_edge();
    bit one_before;
    one_before = (m_cnt == 1);
    if (ld) begin
      m_cnt = int'(load);
    end else if (dec) begin
      if (m_cnt != 0)   m_cnt = m_cnt - 1;
      else if (wrap)    m_cnt = 65535;
      else              m_cnt = 0;
    end
    m_tc = !ld && dec && one_before;
  endtask

  // Apply controls, clock one edge, update model, compare 1ns after the edge.
  task automatic step(input bit ld_i, input logic [15:0] load_i, input bit dec_i,
                      input bit wrap_i, input string name);
    ld   = ld_i;
    load = load_i;
    dec  = dec_i;
    wrap = wrap_i;
    @(posedge clk);
    model_edge();
    #1;
    check(name, m_cnt, m_tc);
    $display("step %-10s ld=%0b load=%h dec=%0b wrap=%0b -> O=%h zero=%0b tc=%0b",
             name, ld_i, load_i, dec_i, wrap_i, O, zero, tc);
  endtask

  // Assert reset between edges and check it takes effect with no clock.
  task automatic async_reset(input string name);
    #2;
    re_n = 1'b0;
    #1;
    m_cnt = 0;
    m_tc  = 1'b0;
    check(name, 0, 1'b0);
    re_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rv;
    re_n = 1'b0;
    load = 16'h0000;
    ld   = 1'b0;
    dec  = 1'b0;
    wrap = 1'b0;
    m_cnt = 0;
    m_tc  = 1'b0;
    #1;
    check("reset", 0, 1'b0);
    // Reset held across an edge with active controls keeps everything clear.
    ld = 1'b1; load = 16'h1234; dec = 1'b1;
    @(posedge clk); #1;
    check("reset_hold", 0, 1'b0);
    @(negedge clk);
    re_n = 1'b1;
    step(0, 16'h0000, 0, 0, "idle");
    check("idle_lit", 16'h0000, 1'b0);

    // Reset mid-count.
    step(1, 16'h0005, 0, 0, "ld5");
    step(0, 16'h0000, 1, 0, "dec");
    step(0, 16'h0000, 1, 0, "dec");
    check("mid_lit", 16'h0003, 1'b0);
    async_reset("rst_mid");

    // Count to terminal.
    step(1, 16'h0003, 0, 0, "ld3");
    step(0, 16'h0000, 1, 0, "dec");
    check("ct2_lit", 16'h0002, 1'b0);
    step(0, 16'h0000, 1, 0, "dec");
    check("ct1_lit", 16'h0001, 1'b0);
    step(0, 16'h0000, 1, 0, "dec");
    check("ct0_lit", 16'h0000, 1'b1);
    step(0, 16'h0000, 1, 0, "sat");
    check("sat_lit", 16'h0000, 1'b0);

    // Underflow with wrap.
    step(0, 16'h0000, 1, 1, "wrap");
    check("wrap_lit", 16'hFFFF, 1'b0);
    step(0, 16'h0000, 1, 0, "dec");
    check("wrapdec_lit", 16'hFFFE, 1'b0);

    // Priority: load beats decrement at count 1.
    step(1, 16'h0001, 0, 0, "ld1");
    step(1, 16'h1234, 1, 0, "ld_dec");
    check("prio_lit", 16'h1234, 1'b0);

    // Loading zero never raises tc.
    step(1, 16'h0001, 0, 0, "ld1");
    step(1, 16'h0000, 0, 0, "ld0");
    check("ld0_lit", 16'h0000, 1'b0);

    // Borrow ripple.
    step(1, 16'h8000, 0, 0, "ld8000");
    step(0, 16'h0000, 1, 0, "dec");
    check("rip1_lit", 16'h7FFF, 1'b0);
    step(1, 16'h0100, 0, 0, "ld0100");
    step(0, 16'h0000, 1, 1, "dec");
    check("rip2_lit", 16'h00FF, 1'b0);

    // Hold.
    step(1, 16'h00A5, 0, 0, "ldA5");
    for (int i = 0; i < 4; i++) step(0, 16'h0000, 0, i[0], "hold");
    check("hold_lit", 16'h00A5, 1'b0);

    // Randomized traffic, biased toward small counts so tc/zero/wrap occur.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = 16'($urandom_range(0, 3));
        1:       rv = 16'($urandom_range(0, 20));
        2:       rv = 16'(1) << $urandom_range(0, 15);
        default: rv = 16'($urandom);
      endcase
      step(($urandom_range(0, 9) == 0), rv, ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1, "rand");
      if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_counter_16.md
# dec_counter_16

Loadable 16-bit down-counter with zero detect and a terminal-count pulse. It is the counting-down counterpart of the program counter. It serves as the loop/delay counter beside the PC in the datapath. The controller loads an iteration count, decrements it once per step, and branches on `zero` or `tc`. It is built from the same gate-level primitives as the PC: NAND-based gates, D flip-flops and 2:1 muxes. Decrement uses a 16-stage half-subtractor borrow chain.

## Interface
Parameters: none. Width is fixed at 16.

- `clk` input 1: single clock. All state updates on the rising edge.
- `re_n` input 1: reset, asynchronous, active-low. Forces all state to reset values immediately, independent of `clk`.
- `load` input 16: value to load.
- `ld` input 1: load enable. Highest synchronous priority.
- `dec` input 1: decrement enable.
- `wrap` input 1: underflow mode. 1 = 0x0000 decrements to 0xFFFF. 0 = saturate at 0x0000.
- `O` output 16: current count, registered.
- `zero` output 1: combinational, 1 when `O == 0x0000` (16-input NOR of `O`).
- `tc` output 1: registered terminal-count pulse.

## Operation
- Reset (`re_n = 0`, any time, including mid-count): `O = 0x0000`, `tc = 0`, `zero = 1`. Reset holds while `re_n` is low. On release, nothing changes until the next rising edge that has an active control.
- Next-state selection at each rising edge, in priority order:
  1. `ld = 1`: `O <= load`; `dec` is ignored.
  2. `dec = 1`, `O != 0`: `O <= O - 1`, modulo 2^16.
  3. `dec = 1`, `O == 0`, `wrap = 1`: `O <= 0xFFFF`.
  4. `dec = 1`, `O == 0`, `wrap = 0`: `O` holds at 0x0000.
  5. Otherwise: `O` holds.
- Decrement: borrow-in = 1 at bit 0, rippling through 16 half-subtractors (diff = a XOR b, borrow = NOT a AND b). The final borrow-out is discarded.
- `tc`: set to 1 at an edge only if `ld = 0`, `dec = 1` and `O == 0x0001` before the edge, so that `O` becomes 0x0000 by decrement. At every other edge `tc` is set to 0.
  - `tc` is therefore a single-cycle pulse, unless software reloads 1 and decrements again.
  - Loading 0x0000 never raises `tc`.
  - A wrap from 0x0000 to 0xFFFF never raises `tc`.
  - A saturated hold at 0 never raises `tc`.
- `zero` follows `O` combinationally. There is no latency beyond the register output.
- Simultaneous `ld` and `dec`: the load wins, the decrement is lost and `tc = 0`.

## Timing
- Every path from a control to `O` or `tc` has one-edge latency. Values are visible after the rising edge, before the next.
- `zero` is valid after the `O` clock-to-out delay plus the NOR depth. The consumer samples it at the next edge.
- Count length: loading N ≥ 1 and holding `dec` continuously gives `O = 0` and `tc = 1` after exactly N edges.
- Asynchronous reset does not need `clk`. `tc` clears within the reset assertion, never at a later edge.
- Inputs must be stable around the rising edge. There are no multicycle paths.
- Critical path: 16-stage borrow ripple, then next-state mux, then flip-flop D.

## Test plan
- Reset mid-count: load 0x0005, decrement 2 edges (`O = 0x0003`), drop `re_n` between edges. Required: `O = 0x0000`, `zero = 1`, `tc = 0` immediately, with no clock edge.
- Count to terminal: load 0x0003, hold `dec = 1`. Required: `O` goes 0x0002, 0x0001, 0x0000. `tc = 1` only in the cycle after the third edge and 0 afterwards. `zero = 1` from the third edge.
- Underflow with `wrap = 1`: `O = 0x0000`, `dec = 1` for one edge. Required: `O = 0xFFFF`, `tc = 0`, `zero = 0`. With `wrap = 0` instead: `O` stays 0x0000 and `tc = 0`.
- Priority: `O = 0x0001`, `ld = 1` with `load = 0x1234`, and `dec = 1` on the same edge. Required: `O = 0x1234` and `tc = 0`.
- Borrow ripple: load 0x8000, decrement once. Required: `O = 0x7FFF`. Then load 0x0100 and decrement once. Required: `O = 0x00FF`.
- Hold: load 0x00A5, then 4 edges with `ld = 0` and `dec = 0`. Required: `O` stays 0x00A5, `tc = 0`, `zero = 0`.
